lc3_fetch_ctrl: RTL and testbench



---
 rtl/lc3_ctrl_pkg.sv | 15 +
 rtl/lc3_bypass_unit.sv | 21 ++
 rtl/lc3_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_lc3_fetch_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: LC3 opcodes, controller FSM states, mem_state codes and opcode helpers
package lc3_ctrl_pkg;
  localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_LD = 4'b0010, OP_ST = 4'b0011,
                         OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                         OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_LEA = 4'b1110;
  typedef enum logic [2:0] {RUN, CTRL_WAIT, MEM_IND, MEM_RD, MEM_WR} ctrl_state_t;
  localparam logic [1:0] MS_READ = 2'd0, MS_IND = 2'd1, MS_WRITE = 2'd2, MS_IDLE = 2'd3;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {OP_LD, OP_LDR, OP_LDI, OP_STI, OP_ST, OP_STR};
  endfunction
  function automatic logic [1:0] mem_code(input ctrl_state_t s);
    return s == MEM_RD ? MS_READ : s == MEM_IND ? MS_IND : s == MEM_WR ? MS_WRITE : MS_IDLE;
  endfunction
endpackage

// File: rtl/lc3_bypass_unit.sv
// lc3_bypass_unit: combinational forwarding selects (i_ir decode instr, i_ir_exec execute instr -> o_alu_1/2, o_mem_1/2)
module lc3_bypass_unit (
  input  logic [15:0] i_ir,
  input  logic [15:0] i_ir_exec,
  output logic        o_alu_1,
  output logic        o_alu_2,
  output logic        o_mem_1,
  output logic        o_mem_2
);
  import lc3_ctrl_pkg::*;
  logic w_alu, w_ld, w_m1, w_m2, w_unused;
  assign w_alu = i_ir_exec[15:12] inside {OP_ADD, OP_AND, OP_NOT};
  assign w_ld = i_ir_exec[15:12] inside {OP_LD, OP_LDR, OP_LDI};
  assign w_m1 = i_ir_exec[11:9] == i_ir[8:6];
  assign w_m2 = i_ir[15:12] inside {OP_ADD, OP_AND} && !i_ir[5] && i_ir_exec[11:9] == i_ir[2:0];
  assign o_alu_1 = w_alu && w_m1;
  assign o_alu_2 = w_alu && w_m2;
  assign o_mem_1 = w_ld && w_m1;
  assign o_mem_2 = w_ld && w_m2;
  assign w_unused = ^{i_ir[11:9], i_ir[4:3], i_ir_exec[8:0]};
endmodule

// File: rtl/lc3_fetch_ctrl.sv
// lc3_fetch_ctrl: LC3 pipeline controller (clock/reset, instr/data completion, IMem_dout/IR/IR_Exec/NZP/psr in; stage enables, br_taken, bypass selects, mem_state out)
module lc3_fetch_ctrl #(
  parameter int CTRL_WAIT_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        br_taken,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);
  import lc3_ctrl_pkg::*;
  localparam int CW = $clog2(CTRL_WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CTRL_WAIT_CYCLES);
  ctrl_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_upc, r_fetch, r_br, r_dec, r_exe, r_wb;
  logic w_upc_nxt, w_fetch_nxt, w_br_nxt, w_dec_nxt, w_exe_nxt, w_wb_nxt;
  logic [1:0] r_ms;
  logic [3:0] r_byp, w_byp;
  logic [3:0] w_op_if, w_op_exe;
  logic w_taken, w_unused;
  assign w_op_if = IMem_dout[15:12];
  assign w_op_exe = IR_Exec[15:12];
  assign w_taken = w_op_exe == OP_JMP || |(NZP & psr);
  assign w_unused = ^IMem_dout[11:0];
  lc3_bypass_unit u_byp (
    .i_ir     (IR),
    .i_ir_exec(IR_Exec),
    .o_alu_1  (w_byp[3]),
    .o_alu_2  (w_byp[2]),
    .o_mem_1  (w_byp[1]),
    .o_mem_2  (w_byp[0])
  );
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    {w_upc_nxt, w_fetch_nxt, w_dec_nxt, w_exe_nxt, w_wb_nxt} = {r_upc, r_fetch, r_dec, r_exe, r_wb};
    w_br_nxt = r_br;
    case (r_state)
      RUN: if (complete_instr) begin
        if (r_exe && is_mem_op(w_op_exe)) begin
          w_state_nxt = w_op_exe inside {OP_LDI, OP_STI} ? MEM_IND : w_op_exe inside {OP_ST, OP_STR} ? MEM_WR : MEM_RD;
          {w_upc_nxt, w_fetch_nxt, w_dec_nxt, w_exe_nxt, w_wb_nxt} = '0;
        end else begin
          {w_dec_nxt, w_exe_nxt, w_wb_nxt} = {r_fetch, r_dec, r_exe};
          if (r_fetch && w_op_if inside {OP_BR, OP_JMP}) begin
            w_state_nxt = CTRL_WAIT;
            w_fetch_nxt = 1'b0;
            w_cnt_nxt = CW'(1);
            w_upc_nxt = CW'(1) == CNT_LAST;
            w_br_nxt = w_upc_nxt && w_taken;
          end
        end
      end
      CTRL_WAIT: begin
        {w_dec_nxt, w_exe_nxt, w_wb_nxt} = {r_fetch, r_dec, r_exe};
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt = '0;
          {w_upc_nxt, w_fetch_nxt, w_br_nxt} = 3'b110;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_upc_nxt = w_cnt_nxt == CNT_LAST;
          w_br_nxt = w_upc_nxt && w_taken;
        end
      end
      MEM_IND: if (complete_data) w_state_nxt = w_op_exe == OP_STI ? MEM_WR : MEM_RD;
      MEM_RD, MEM_WR: if (complete_data) begin
        w_state_nxt = RUN;
        {w_upc_nxt, w_fetch_nxt, w_dec_nxt, w_exe_nxt, w_wb_nxt} = {4'hF, r_state == MEM_RD};
      end
      default: w_state_nxt = RUN;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt <= '0;
      {r_upc, r_fetch, r_dec, r_exe, r_wb, r_br} <= 6'b110000;
      r_ms <= MS_IDLE;
      r_byp <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      {r_upc, r_fetch, r_dec, r_exe, r_wb, r_br} <= {w_upc_nxt, w_fetch_nxt, w_dec_nxt, w_exe_nxt, w_wb_nxt, w_br_nxt};
      r_ms <= mem_code(w_state_nxt);
      if (r_dec) r_byp <= w_byp;
    end
  end
  assign {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback} = {r_upc, r_fetch, r_dec, r_exe, r_wb};
  assign br_taken = r_br;
  assign {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = r_byp;
  assign mem_state = r_ms;
endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// tb_lc3_fetch_ctrl: directed and randomized self-checking bench for lc3_fetch_ctrl
module tb_lc3_fetch_ctrl;
  logic clock, reset, complete_instr, complete_data;
  logic [15:0] IMem_dout, IR, IR_Exec;
  logic [2:0] NZP, psr;
  logic enable_updatePC, enable_fetch, br_taken, enable_decode, enable_execute, enable_writeback;
  logic bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0] mem_state;
  logic [4:0] en;
  logic [3:0] byp;
  int checks = 0;
  int failures = 0;
  lc3_fetch_ctrl dut (
    .clock(clock), .reset(reset), .complete_instr(complete_instr), .complete_data(complete_data),
    .IMem_dout(IMem_dout), .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP), .psr(psr),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch), .br_taken(br_taken),
    .enable_decode(enable_decode), .enable_execute(enable_execute), .enable_writeback(enable_writeback),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2), .bypass_mem_1(bypass_mem_1),
    .bypass_mem_2(bypass_mem_2), .mem_state(mem_state)
  );
  assign en = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
  assign byp = {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] exp_byp(input logic [15:0] ir, input logic [15:0] x);
    logic alu, ld, m1, m2;
    alu = x[15:12] inside {4'h1, 4'h5, 4'h9};
    ld = x[15:12] inside {4'h2, 4'h6, 4'hA};
    m1 = x[11:9] == ir[8:6];
    m2 = ir[15:12] inside {4'h1, 4'h5} && !ir[5] && x[11:9] == ir[2:0];
    return {alu && m1, alu && m2, ld && m1, ld && m2};
  endfunction
  task automatic run_mem(input logic [15:0] instr, input int w);
    logic [1:0] q[$];
    logic ld;
    ld = instr[15:12] inside {4'h2, 4'h6, 4'hA};
    if (instr[15:12] inside {4'hA, 4'hB}) q.push_back(2'd1);
    q.push_back(ld ? 2'd0 : 2'd2);
    IR_Exec = instr;
    complete_data = 1'b0;
    foreach (q[i]) begin
      step();
      complete_data = 1'b0;
      chk("mem_state", 16'(mem_state), 16'(q[i]));
      chk("mem_enables", 16'(en), 16'h0);
      repeat (w) begin
        step();
        chk("mem_wait_state", 16'(mem_state), 16'(q[i]));
        chk("mem_wait_enables", 16'(en), 16'h0);
      end
      complete_data = 1'b1;
      if (i == q.size() - 1) IR_Exec = 16'h1000;
    end
    step();
    complete_data = 1'b0;
    chk("mem_done_state", 16'(mem_state), 16'd3);
    chk("mem_done_enables", 16'(en), ld ? 16'h1F : 16'h1E);
  endtask
  task automatic run_br(input logic [15:0] instr, input logic [2:0] nzp, input logic [2:0] p);
    logic tk;
    tk = instr[15:12] == 4'hC ? 1'b1 : |(nzp & p);
    IMem_dout = instr;
    NZP = nzp;
    psr = p;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin
        IMem_dout = 16'h1000;
        IR_Exec = instr;
      end
      chk("br_fetch", 16'(enable_fetch), 16'h0);
      chk("br_updatepc", 16'(enable_updatePC), 16'(k == 3));
      chk("br_taken", 16'(br_taken), 16'(k == 3 && tk));
      chk("br_decode_bubble", 16'(enable_decode), 16'(k == 1));
    end
    step();
    chk("br_resume", 16'({enable_fetch, enable_updatePC, br_taken}), 16'h6);
    IR_Exec = 16'h1000;
    repeat (3) step();
  endtask
  initial begin
    logic [3:0] ops [6];
    logic [3:0] mops [6];
    logic [15:0] ir, x, instr;
    logic [2:0] nzp, p;
    ops = '{4'h1, 4'h5, 4'h9, 4'h0, 4'h4, 4'hE};
    mops = '{4'h2, 4'h6, 4'hA, 4'hB, 4'h3, 4'h7};
    reset = 1'b1;
    complete_instr = 1'b1;
    complete_data = 1'b0;
    IMem_dout = 16'h1000;
    IR = 16'h0000;
    IR_Exec = 16'h1000;
    NZP = 3'b000;
    psr = 3'b010;
    step();
    step();
    chk("rst_enables", 16'(en), 16'h18);
    chk("rst_br_taken", 16'(br_taken), 16'h0);
    chk("rst_bypass", 16'(byp), 16'h0);
    chk("rst_mem_state", 16'(mem_state), 16'd3);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rise_decode", 16'(enable_decode), 16'h1);
      chk("rise_execute", 16'(enable_execute), 16'(k >= 2));
      chk("rise_writeback", 16'(enable_writeback), 16'(k >= 3));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    complete_instr = 1'b0;
    step();
    step();
    chk("hold_enables", 16'(en), 16'h18);
    complete_instr = 1'b1;
    repeat (3) step();
    chk("refill_enables", 16'(en), 16'h1F);
    IR = 16'h1841;
    IR_Exec = 16'h1283;
    step();
    chk("bypass_alu_both", 16'(byp), 16'hC);
    for (int n = 0; n < 16; n++) begin
      x = {ops[$urandom_range(0, 5)], 12'($urandom)};
      ir = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ir[8:6] = x[11:9];
      if ($urandom_range(0, 1) == 1) ir[2:0] = x[11:9];
      IR = ir;
      IR_Exec = x;
      step();
      chk("bypass_rand", 16'(byp), 16'(exp_byp(ir, x)));
    end
    IR = 16'h1000;
    IR_Exec = 16'h1000;
    step();
    run_mem(16'hA000, 5);
    IR = 16'h1841;
    IR_Exec = 16'h2200;
    step();
    chk("bypass_mem_both", 16'(byp), 16'h3);
    chk("ld_mem_state", 16'(mem_state), 16'd0);
    IR = 16'h1000;
    step();
    chk("bypass_hold", 16'(byp), 16'h3);
    complete_data = 1'b1;
    IR_Exec = 16'h1000;
    step();
    complete_data = 1'b0;
    chk("ld_done_state", 16'(mem_state), 16'd3);
    chk("ld_done_wb", 16'(enable_writeback), 16'h1);
    for (int n = 0; n < 6; n++) run_mem({mops[$urandom_range(0, 5)], 12'($urandom)}, int'($urandom_range(0, 3)));
    run_br(16'h0805, 3'b100, 3'b100);
    run_br(16'h0405, 3'b010, 3'b001);
    for (int n = 0; n < 8; n++) begin
      p = 3'b001 << $urandom_range(0, 2);
      nzp = 3'($urandom);
      instr = ($urandom_range(0, 1) == 1) ? {4'h0, nzp, 9'($urandom)} : {4'hC, 3'b000, 3'($urandom), 6'b000000};
      run_br(instr, nzp, p);
    end
    IMem_dout = 16'h0E05;
    IR_Exec = 16'h2000;
    step();
    chk("prio_mem_state", 16'(mem_state), 16'd0);
    chk("prio_fetch_off", 16'(enable_fetch), 16'h0);
    complete_data = 1'b1;
    IR_Exec = 16'h1000;
    step();
    complete_data = 1'b0;
    chk("prio_return_state", 16'(mem_state), 16'd3);
    chk("prio_return_fetch", 16'(enable_fetch), 16'h1);
    step();
    chk("prio_ctrl_fetch", 16'(enable_fetch), 16'h0);
    chk("prio_ctrl_state", 16'(mem_state), 16'd3);
    IMem_dout = 16'h1000;
    repeat (3) step();
    chk("prio_resume", 16'(enable_fetch), 16'h1);
    repeat (3) step();
    IR_Exec = 16'h3001;
    step();
    chk("st_mem_state", 16'(mem_state), 16'd2);
    step();
    chk("st_wait_state", 16'(mem_state), 16'd2);
    reset = 1'b1;
    IR_Exec = 16'h1000;
    step();
    reset = 1'b0;
    chk("st_rst_state", 16'(mem_state), 16'd3);
    chk("st_rst_enables", 16'(en), 16'h18);
    chk("st_rst_br", 16'(br_taken), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
